// File: rtl/chimera_eoc_mailbox_if.sv
// Register-bus port bundle for the end-of-computation mailbox.
// The master drives the request side; the slave (the mailbox) returns
// the grant and a one-cycle-delayed response.
interface chimera_eoc_mailbox_if #(
  parameter int unsigned AddrWidth = 8
);
  logic                 req_i;
  logic                 we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [3:0]           be_i;
  logic [31:0]          wdata_i;
  logic                 gnt_o;
  logic                 rvalid_o;
  logic [31:0]          rdata_o;
  logic                 err_o;

  modport master (
    output req_i, we_i, addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/chimera_eoc_mailbox.sv
// End-of-computation mailbox: software writes its exit code and done flag,
// the block counts run cycles and presents eoc_valid_o / exit_code_o.
// Optional watchdog: define CHIMERA_EOC_WATCHDOG_EN to add the WDT_LIMIT
// register at offset 0x14 and the sticky TIMEOUT state.
module chimera_eoc_mailbox #(
  parameter int unsigned AddrWidth   = 8,
  parameter logic [31:0] TimeoutCode = 32'hDEAD_0001,
  parameter int unsigned CntWidth    = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  chimera_eoc_mailbox_if.slave bus,
  output logic                 eoc_valid_o,
  output logic [31:0]          exit_code_o,
  output logic                 running_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [2:0] OFF_EOC    = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CYC_LO = 3'd2;
  localparam logic [2:0] OFF_CYC_HI = 3'd3;
  localparam logic [2:0] OFF_START  = 3'd4;
  localparam logic [2:0] OFF_WDT    = 3'd5;

  state_e                state_q, state_d;
  logic [31:0]           eoc_q;
  logic [CntWidth-1:0]   cnt_q;
  logic [63:0]           cnt_ext;
  logic [AddrWidth-1:0]  addr;
  logic [2:0]            word_idx;
  logic                  unused_addr;
  logic                  wr_eoc;
  logic                  wr_start;
  logic                  wdt_expired;
  logic [31:0]           eoc_merged;
  logic [31:0]           rd_data;
  logic                  rd_err;
  logic                  status_timeout;
  logic [3:0]            status;
  logic                  rvalid_p1;
  logic                  err_p1;
  logic [31:0]           rdata_p1;
`ifdef CHIMERA_EOC_WATCHDOG_EN
  logic [31:0]           wdt_q;
  logic                  wr_wdt;
`endif

  // Byte-lane merge of a bus write into an existing register value.
  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  // Cycle counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + CntWidth'(1);
  endfunction

  assign addr        = bus.addr_i;
  assign word_idx    = addr[4:2];
  assign unused_addr = ^{addr[AddrWidth-1:5], addr[1:0]};
  assign cnt_ext     = 64'(cnt_q);
  assign eoc_merged  = merge_be(eoc_q, bus.wdata_i, bus.be_i);
  assign status      = {state_q, status_timeout, eoc_valid_o};

`ifdef CHIMERA_EOC_WATCHDOG_EN
  assign wdt_expired = (wdt_q != 32'd0) && (cnt_q[31:0] >= wdt_q);
`else
  assign wdt_expired = 1'b0;
`endif

  // Address decode: write strobes, read data and error flag for this request.
  always_comb begin
    wr_eoc   = 1'b0;
    wr_start = 1'b0;
    rd_data  = 32'd0;
    rd_err   = 1'b0;
`ifdef CHIMERA_EOC_WATCHDOG_EN
    wr_wdt   = 1'b0;
`endif
    if (bus.req_i) begin
      case (word_idx)
        OFF_EOC: begin
          if (bus.we_i) wr_eoc = 1'b1;
          else          rd_data = eoc_q;
        end
        OFF_STATUS: begin
          if (bus.we_i) rd_err = 1'b1;
          else          rd_data = {28'd0, status};
        end
        OFF_CYC_LO: begin
          if (bus.we_i) rd_err = 1'b1;
          else          rd_data = cnt_ext[31:0];
        end
        OFF_CYC_HI: begin
          if (bus.we_i) rd_err = 1'b1;
          else          rd_data = cnt_ext[63:32];
        end
        OFF_START: begin
          // Reads of START return zero; only a write with some lane enabled starts.
          if (bus.we_i) wr_start = |bus.be_i;
        end
`ifdef CHIMERA_EOC_WATCHDOG_EN
        OFF_WDT: begin
          if (bus.we_i) wr_wdt = 1'b1;
          else          rd_data = wdt_q;
        end
`endif
        default: rd_err = 1'b1;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: START beats everything, a done write beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (wr_start)                         state_d = ST_RUNNING;
        else if (wr_eoc && eoc_merged[0])     state_d = ST_DONE;
      end
      ST_RUNNING: begin
        if (wr_start)                         state_d = ST_RUNNING;
        else if (wr_eoc && eoc_merged[0])     state_d = ST_DONE;
        else if (wdt_expired)                 state_d = ST_TIMEOUT;
      end
      ST_DONE: begin
        if (wr_start)                         state_d = ST_RUNNING;
      end
      ST_TIMEOUT: begin
        if (wr_start)                         state_d = ST_RUNNING;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state only.
  always_comb begin
    eoc_valid_o    = 1'b0;
    exit_code_o    = 32'd0;
    running_o      = 1'b0;
    status_timeout = 1'b0;
    case (state_q)
      ST_RUNNING: running_o = 1'b1;
      ST_DONE: begin
        eoc_valid_o = 1'b1;
        exit_code_o = {1'b0, eoc_q[31:1]};
      end
      ST_TIMEOUT: begin
        eoc_valid_o = 1'b1;
        exit_code_o = TimeoutCode;
`ifdef CHIMERA_EOC_WATCHDOG_EN
        status_timeout = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // EOC register: byte-merged writes; a restart out of DONE wipes it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              eoc_q <= 32'd0;
    else if (wr_start && state_q == ST_DONE)  eoc_q <= 32'd0;
    else if (wr_eoc)                          eoc_q <= eoc_merged;
  end

  // Run-cycle counter: cleared by START, counts only while RUNNING.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     cnt_q <= '0;
    else if (wr_start)               cnt_q <= '0;
    else if (state_q == ST_RUNNING)  cnt_q <= sat_inc(cnt_q);
  end

`ifdef CHIMERA_EOC_WATCHDOG_EN
  // Watchdog limit register with byte-lane writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     wdt_q <= 32'd0;
    else if (wr_wdt) wdt_q <= merge_be(wdt_q, bus.wdata_i, bus.be_i);
  end
`endif

  // Stage p0 -> p1: bus response registered one cycle after each request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_p1 <= 1'b0;
      rdata_p1  <= 32'd0;
      err_p1    <= 1'b0;
    end else begin
      rvalid_p1 <= bus.req_i;
      rdata_p1  <= rd_data;
      err_p1    <= rd_err;
    end
  end

  assign bus.gnt_o    = bus.req_i;
  assign bus.rvalid_o = rvalid_p1;
  assign bus.rdata_o  = rdata_p1;
  assign bus.err_o    = err_p1;

endmodule

// File: tb/tb_chimera_eoc_mailbox.sv
// Directed bench for the EOC mailbox. The stimulus process pushes the
// expected bus response for each access; a negedge monitor pops and compares
// whenever rvalid_o is presented, and checks grant/response timing each cycle.
module tb_chimera_eoc_mailbox;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eoc_valid;
  logic [31:0] exit_code;
  logic        running;
  logic        req_seen;
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  chimera_eoc_mailbox_if #(.AddrWidth(8)) bus_if ();

  chimera_eoc_mailbox #(
    .AddrWidth  (8),
    .TimeoutCode(32'hDEAD_0001),
    .CntWidth   (64)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus_if),
    .eoc_valid_o(eoc_valid),
    .exit_code_o(exit_code),
    .running_o  (running)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  // One bus access, one cycle long; called and returning at posedge+1.
  task automatic bus(input logic we, input logic [7:0] addr, input logic [3:0] be,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input string name);
    exp_t e;
    e.name  = name;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    bus_if.req_i   = 1'b1;
    bus_if.we_i    = we;
    bus_if.addr_i  = addr;
    bus_if.be_i    = be;
    bus_if.wdata_i = wdata;
    @(posedge clk); #1;
    bus_if.req_i   = 1'b0;
    bus_if.we_i    = 1'b0;
    bus_if.addr_i  = 8'd0;
    bus_if.be_i    = 4'd0;
    bus_if.wdata_i = 32'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference for response timing: a response is owed one cycle after each request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_seen <= 1'b0;
    else        req_seen <= bus_if.req_i;
  end

  // Monitor: grant, response timing and scoreboard comparison.
  always @(negedge clk) begin
    if (rst_n) begin
      check1("gnt", bus_if.gnt_o, bus_if.req_i);
      check1("rvalid timing", bus_if.rvalid_o, req_seen);
      if (bus_if.rvalid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected response rdata=0x%08h err=%b", bus_if.rdata_o, bus_if.err_o);
        end else begin
          mon_e = exp_q.pop_front();
          check32({mon_e.name, " rdata"}, bus_if.rdata_o, mon_e.rdata);
          check1({mon_e.name, " err"}, bus_if.err_o, mon_e.err);
        end
      end else begin
        check32("rdata idle", bus_if.rdata_o, 32'd0);
        check1("err idle", bus_if.err_o, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    bus_if.req_i   = 1'b0;
    bus_if.we_i    = 1'b0;
    bus_if.addr_i  = 8'd0;
    bus_if.be_i    = 4'd0;
    bus_if.wdata_i = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check1("reset eoc_valid", eoc_valid, 1'b0);
    check1("reset running", running, 1'b0);
    check32("reset exit_code", exit_code, 32'd0);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'd0, 1'b0, "rd STATUS reset");
    bus(1'b0, 8'h00, 4'hF, 32'd0, 32'd0, 1'b0, "rd EOC reset");
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd0, 1'b0, "rd CYC_LO reset");
    bus(1'b0, 8'h0C, 4'hF, 32'd0, 32'd0, 1'b0, "rd CYC_HI reset");
    idle(2);

    // Run for 100 idle cycles, then report done with code 0
    bus(1'b1, 8'h10, 4'hF, 32'd0, 32'd0, 1'b0, "wr START");
    check1("running after START", running, 1'b1);
    check1("eoc_valid after START", eoc_valid, 1'b0);
    idle(100);
    bus(1'b1, 8'h00, 4'hF, 32'h0000_0001, 32'd0, 1'b0, "wr EOC done");
    check1("eoc_valid after done", eoc_valid, 1'b1);
    check32("exit_code after done", exit_code, 32'd0);
    check1("running after done", running, 1'b0);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h9, 1'b0, "rd STATUS done");
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd101, 1'b0, "rd CYC_LO at done");
    bus(1'b0, 8'h0C, 4'hF, 32'd0, 32'd0, 1'b0, "rd CYC_HI at done");
    idle(10);
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd101, 1'b0, "rd CYC_LO frozen");

    // Byte-lane write while DONE, then restart
    bus(1'b1, 8'h00, 4'b0001, 32'h0000_0054, 32'd0, 1'b0, "wr EOC byte0");
    check32("exit_code byte0", exit_code, 32'h0000_002A);
    check1("eoc_valid sticky", eoc_valid, 1'b1);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h9, 1'b0, "rd STATUS sticky");
    bus(1'b1, 8'h10, 4'hF, 32'd0, 32'd0, 1'b0, "wr START from DONE");
    check1("running restart", running, 1'b1);
    check1("eoc_valid restart", eoc_valid, 1'b0);
    check32("exit_code restart", exit_code, 32'd0);
    bus(1'b0, 8'h00, 4'hF, 32'd0, 32'd0, 1'b0, "rd EOC cleared");
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h4, 1'b0, "rd STATUS running");

    // Code without done keeps running; a byte write setting done finishes
    bus(1'b1, 8'h00, 4'hF, 32'hFFFF_FFFE, 32'd0, 1'b0, "wr EOC no done");
    check1("running no done", running, 1'b1);
    check1("eoc_valid no done", eoc_valid, 1'b0);
    bus(1'b0, 8'h00, 4'hF, 32'd0, 32'hFFFF_FFFE, 1'b0, "rd EOC no done");
    bus(1'b1, 8'h00, 4'b0001, 32'h0000_00FF, 32'd0, 1'b0, "wr EOC byte0 done");
    check1("eoc_valid byte0 done", eoc_valid, 1'b1);
    check32("exit_code all ones", exit_code, 32'h7FFF_FFFF);

    // Errors and read-only protection; counter stopped at 5 cycles after restart
    bus(1'b0, 8'h18, 4'hF, 32'd0, 32'd0, 1'b1, "rd unmapped 0x18");
    bus(1'b0, 8'h1C, 4'hF, 32'd0, 32'd0, 1'b1, "rd unmapped 0x1C");
    bus(1'b1, 8'h08, 4'hF, 32'h0000_1234, 32'd0, 1'b1, "wr CYC_LO ro");
    bus(1'b1, 8'h04, 4'hF, 32'h0000_0000, 32'd0, 1'b1, "wr STATUS ro");
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd5, 1'b0, "rd CYC_LO unchanged");
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h9, 1'b0, "rd STATUS after ro wr");
    bus(1'b0, 8'h10, 4'hF, 32'd0, 32'd0, 1'b0, "rd START");
    bus(1'b1, 8'h10, 4'b0000, 32'd0, 32'd0, 1'b0, "wr START no be");
    check1("eoc_valid after no-be START", eoc_valid, 1'b1);
    check32("exit_code after no-be START", exit_code, 32'h7FFF_FFFF);

`ifdef CHIMERA_EOC_WATCHDOG_EN
    // Watchdog expiry with no EOC write
    bus(1'b1, 8'h14, 4'hF, 32'd50, 32'd0, 1'b0, "wr WDT_LIMIT");
    bus(1'b0, 8'h14, 4'hF, 32'd0, 32'd50, 1'b0, "rd WDT_LIMIT");
    bus(1'b1, 8'h10, 4'hF, 32'd0, 32'd0, 1'b0, "wr START wdt");
    n = 0;
    while (!eoc_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n < 50 || n > 51) begin
      failures++;
      $display("FAIL timeout latency actual=%0d required=50..51", n);
    end
    check32("exit_code timeout", exit_code, 32'hDEAD_0001);
    check1("running timeout", running, 1'b0);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'hF, 1'b0, "rd STATUS timeout");
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd51, 1'b0, "rd CYC_LO timeout");
    bus(1'b1, 8'h00, 4'hF, 32'h0000_0003, 32'd0, 1'b0, "wr EOC in TIMEOUT");
    check32("exit_code timeout sticky", exit_code, 32'hDEAD_0001);
`else
    // Watchdog offset is unmapped in this build
    bus(1'b0, 8'h14, 4'hF, 32'd0, 32'd0, 1'b1, "rd WDT unmapped");
    bus(1'b1, 8'h14, 4'hF, 32'd50, 32'd0, 1'b1, "wr WDT unmapped");
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h9, 1'b0, "rd STATUS no timeout");
`endif
    idle(2);

    // Reset while a finished run is presented
    rst_n = 1'b0;
    #1;
    check1("reset eoc_valid done", eoc_valid, 1'b0);
    check32("reset exit_code done", exit_code, 32'd0);
    check1("reset rvalid done", bus_if.rvalid_o, 1'b0);
    idle(2);
    rst_n = 1'b1;

    // Reset mid-run with a response in flight: it must be discarded
    bus(1'b1, 8'h10, 4'hF, 32'd0, 32'd0, 1'b0, "wr START pre-reset");
    idle(5);
    check1("running pre-reset", running, 1'b1);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'h4, 1'b0, "rd STATUS discarded");
    rst_n = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    #1;
    check1("reset running", running, 1'b0);
    check1("reset rvalid", bus_if.rvalid_o, 1'b0);
    check32("reset rdata", bus_if.rdata_o, 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    bus(1'b0, 8'h04, 4'hF, 32'd0, 32'd0, 1'b0, "rd STATUS after reset");
    bus(1'b0, 8'h08, 4'hF, 32'd0, 32'd0, 1'b0, "rd CYC_LO after reset");
    bus(1'b0, 8'h00, 4'hF, 32'd0, 32'd0, 1'b0, "rd EOC after reset");
`ifdef CHIMERA_EOC_WATCHDOG_EN
    bus(1'b0, 8'h14, 4'hF, 32'd0, 32'd0, 1'b0, "rd WDT_LIMIT after reset");
`endif
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing responses actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
